openfire_regfile_mp: RTL and testbench

Parametrised multi-port register file for the OpenFire datapath. It provides NUM_READ asynchronous read ports and one synchronous write port with optional write-through bypass. A hardware clear sweep after reset zeroes every register. A single-entry load scoreboard accepts returning data-memory words after variable latency, extracts and extends them, writes them back, and flags read hazards against the pending destination. It sits between DECODE (read addresses), EXECUTE (ALU/PC results) and the DMEM arbiter (load data).

---
 rtl/openfire_regfile_mp.sv | 198 +++++++++++++++++++
 tb/tb_openfire_regfile_mp.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/openfire_regfile_mp.sv
// Multi-port register file for the OpenFire datapath: asynchronous reads, one arbitrated write
// port (load return over ALU), post-reset clear sweep and a single-entry load scoreboard.
module openfire_regfile_mp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 3,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned R0_ZERO    = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic                           wr_pc_sel,
  input  logic [DATA_WIDTH-1:0]          result,
  input  logic [DATA_WIDTH-1:0]          pc,
  output logic                           wr_stall,
  input  logic                           ld_issue,
  input  logic [ADDR_WIDTH-1:0]          ld_dest,
  input  logic [1:0]                     ld_size,
  input  logic                           ld_sext,
  output logic                           ld_ready,
  input  logic                           dmem_valid,
  input  logic [DATA_WIDTH-1:0]          dmem_data,
  output logic                           hazard,
  output logic                           init_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  localparam logic StClear = 1'b0;
  localparam logic StRun   = 1'b1;

  logic                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
  logic                  ld_pending_q, ld_pending_d;
  logic [ADDR_WIDTH-1:0] ld_dest_q, ld_dest_d;
  logic [1:0]            ld_size_q, ld_size_d;
  logic                  ld_sext_q, ld_sext_d;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];

  logic                  run;
  logic                  ld_return;
  logic                  alu_commit;
  logic                  ld_accept;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  hazard_hit;
  logic [ADDR_WIDTH-1:0] ra;
  logic [DATA_WIDTH-1:0] rv;

  assign run        = (state_q == StRun);
  assign init_busy  = ~run;
  assign ld_return  = run & dmem_valid & ld_pending_q;
  assign wr_stall   = run & wr_en & enable & dmem_valid & ld_pending_q;
  assign alu_commit = run & wr_en & enable & ~wr_stall;
  assign ld_ready   = run & (~ld_pending_q | dmem_valid);
  assign ld_accept  = ld_issue & enable & ld_ready;

  // The arbiter left-aligns sub-word loads, so the payload is always at the MSBs.
  assign ld_byte = dmem_data[DATA_WIDTH-1 -: 8];
  assign ld_half = dmem_data[DATA_WIDTH-1 -: 16];

  always_comb begin
    ld_data = dmem_data;
    case (ld_size_q)
      2'd0:    ld_data = {{(DATA_WIDTH - 8){ld_sext_q & ld_byte[7]}}, ld_byte};
      2'd1:    ld_data = {{(DATA_WIDTH - 16){ld_sext_q & ld_half[15]}}, ld_half};
      default: ld_data = dmem_data;
    endcase
  end

  // Single write port: sweep, then load return, then ALU/PC result.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (!run) begin
      we    = 1'b1;
      waddr = sweep_q;
    end else if (ld_return) begin
      we    = 1'b1;
      waddr = ld_dest_q;
      wdata = ld_data;
    end else if (alu_commit) begin
      we    = 1'b1;
      waddr = wr_addr;
      wdata = wr_pc_sel ? pc : result;
    end
    if (R0_ZERO != 0 && run && waddr == '0) begin
      we = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    ld_pending_d = ld_pending_q;
    ld_dest_d    = ld_dest_q;
    ld_size_d    = ld_size_q;
    ld_sext_d    = ld_sext_q;
    if (!run) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == '1) begin
        state_d = StRun;
      end
    end else begin
      if (ld_return) begin
        ld_pending_d = 1'b0;
      end
      // A new issue in the return cycle re-arms the entry with the new capture.
      if (ld_accept) begin
        ld_pending_d = 1'b1;
        ld_dest_d    = ld_dest;
        ld_size_d    = ld_size;
        ld_sext_d    = ld_sext;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StClear;
      sweep_q      <= '0;
      ld_pending_q <= 1'b0;
      ld_dest_q    <= '0;
      ld_size_q    <= 2'd0;
      ld_sext_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      ld_pending_q <= ld_pending_d;
      ld_dest_q    <= ld_dest_d;
      ld_size_q    <= ld_size_d;
      ld_sext_q    <= ld_sext_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && we) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    hazard_hit = 1'b0;
    for (int i = 0; i < NUM_READ; i++) begin
      if (rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == ld_dest_q) begin
        hazard_hit = 1'b1;
      end
    end
    hazard = run & ld_pending_q & hazard_hit;
    // With bypass the returning word is forwarded, so the return cycle is hazard-free.
    if (BYPASS != 0 && dmem_valid) begin
      hazard = 1'b0;
    end
    if (R0_ZERO != 0 && ld_dest_q == '0) begin
      hazard = 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    ra      = '0;
    rv      = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      ra = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      rv = regs_q[ra];
      if (BYPASS != 0 && we && waddr == ra) begin
        rv = wdata;
      end
      if (R0_ZERO != 0 && ra == '0) begin
        rv = '0;
      end
      if (!run) begin
        rv = '0;
      end
      rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rv;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset && run && dmem_valid && !ld_pending_q) begin
      $error("openfire_regfile_mp: dmem_valid with no pending load ignored");
    end
  end
`endif

endmodule

// File: tb/tb_openfire_regfile_mp.sv
// Self-checking bench for openfire_regfile_mp: directed scenarios plus a randomized run against
// a behavioural register-file/scoreboard model.
module tb_openfire_regfile_mp;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [14:0] rd_addr;
  logic [95:0] rd_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic        wr_pc_sel;
  logic [31:0] result;
  logic [31:0] pc;
  logic        wr_stall;
  logic        ld_issue;
  logic [4:0]  ld_dest;
  logic [1:0]  ld_size;
  logic        ld_sext;
  logic        ld_ready;
  logic        dmem_valid;
  logic [31:0] dmem_data;
  logic        hazard;
  logic        init_busy;

  int checks = 0;
  int errors = 0;

  openfire_regfile_mp dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_pc_sel  (wr_pc_sel),
    .result     (result),
    .pc         (pc),
    .wr_stall   (wr_stall),
    .ld_issue   (ld_issue),
    .ld_dest    (ld_dest),
    .ld_size    (ld_size),
    .ld_sext    (ld_sext),
    .ld_ready   (ld_ready),
    .dmem_valid (dmem_valid),
    .dmem_data  (dmem_data),
    .hazard     (hazard),
    .init_busy  (init_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    enable = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_pc_sel = 1'b0;
    result = '0; pc = '0; ld_issue = 1'b0; ld_dest = '0; ld_size = 2'd0; ld_sext = 1'b0;
    dmem_valid = 1'b0; dmem_data = '0;
  endtask

  function automatic logic [31:0] port(input int p);
    return rd_data[p*32 +: 32];
  endfunction

  // Sub-word loads live in the MSBs; extension chosen by size/sext.
  function automatic logic [31:0] ld_model(input logic [31:0] d, input int size, input bit sext);
    logic [31:0] v;
    if (size == 0) begin
      v = d >> 24;
      if (sext && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = d >> 16;
      if (sext && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  task automatic wait_sweep(output int n);
    n = 0;
    while (init_busy === 1'b1 && n < 100) begin
      n++;
      tick();
      dmem_valid = 1'b0;
      settle();
    end
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    wr_en = 1'b1; wr_addr = 5'd9; result = 32'hABCD_0123; ld_issue = 1'b1; ld_dest = 5'd9;
    dmem_valid = 1'b1; rd_addr = {5'd1, 5'd9, 5'd5};
    settle();
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_init_busy got %b exp 1", init_busy); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready got %b exp 0", ld_ready); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b exp 0", hazard); end
    checks++; if (wr_stall !== 1'b0) begin errors++; $display("FAIL reset_wr_stall got %b exp 0", wr_stall); end
    checks++; if (rd_data !== 96'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    tick();
    reset = 1'b0;
    settle();
    n = 0;
    while (init_busy === 1'b1 && n < 100) begin
      n++;
      if (n == 6) begin wr_en = 1'b0; ld_issue = 1'b0; dmem_valid = 1'b0; end
      if (ld_ready !== 1'b0 || wr_stall !== 1'b0 || hazard !== 1'b0 || rd_data !== 96'h0) begin
        errors++;
        $display("FAIL sweep_outputs cycle %0d got rdy %b stall %b haz %b rd %h exp all 0",
                 n, ld_ready, wr_stall, hazard, rd_data);
      end
      checks++;
      tick();
      settle();
    end
    checks++; if (n != 32) begin errors++; $display("FAIL sweep_length got %0d exp 32", n); end
    wr_en = 1'b0; ld_issue = 1'b0; dmem_valid = 1'b0;
    for (int a = 0; a < 32; a += 3) begin
      rd_addr = {5'(a + 2), 5'(a + 1), 5'(a)};
      settle();
      checks++;
      if (rd_data !== 96'h0) begin errors++; $display("FAIL clear_regs base %0d got %h exp 0", a, rd_data); end
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    wr_en = 1'b1; wr_addr = 5'd5; result = 32'hDEAD_BEEF; rd_addr = {5'd0, 5'd5, 5'd0};
    settle();
    checks++; if (port(1) !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_same_cycle got %h exp deadbeef", port(1)); end
    tick();
    wr_en = 1'b0;
    settle();
    checks++; if (port(1) !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_next_cycle got %h exp deadbeef", port(1)); end
    wr_en = 1'b1; wr_addr = 5'd6; wr_pc_sel = 1'b1; pc = 32'h0000_4A3C; rd_addr = {5'd6, 5'd0, 5'd0};
    settle();
    checks++; if (port(2) !== 32'h0000_4A3C) begin errors++; $display("FAIL pc_write got %h exp 00004a3c", port(2)); end
    tick();
    idle_inputs();
  endtask

  task automatic test_r0();
    idle_inputs();
    wr_en = 1'b1; wr_addr = 5'd0; result = 32'h1234_5678; rd_addr = {5'd0, 5'd0, 5'd0};
    settle();
    checks++; if (rd_data !== 96'h0) begin errors++; $display("FAIL r0_bypass got %h exp 0", rd_data); end
    tick();
    wr_en = 1'b0;
    settle();
    checks++; if (port(0) !== 32'h0) begin errors++; $display("FAIL r0_after got %h exp 0", port(0)); end
  endtask

  task automatic do_load(input int dest, input int size, input bit sext, input logic [31:0] data,
                         input logic [31:0] exp, input string nm);
    idle_inputs();
    ld_issue = 1'b1; ld_dest = 5'(dest); ld_size = 2'(size); ld_sext = sext;
    settle();
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL %s_ready got %b exp 1", nm, ld_ready); end
    tick();
    ld_issue = 1'b0; rd_addr = {5'(dest), 5'd0, 5'd0};
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL %s_hazard cyc %0d got %b exp 1", nm, c, hazard); end
      tick();
    end
    dmem_valid = 1'b1; dmem_data = data;
    settle();
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL %s_hazard_ret got %b exp 0", nm, hazard); end
    checks++; if (port(2) !== exp) begin errors++; $display("FAIL %s_bypass got %h exp %h", nm, port(2), exp); end
    tick();
    dmem_valid = 1'b0;
    settle();
    checks++; if (port(2) !== exp) begin errors++; $display("FAIL %s_value got %h exp %h", nm, port(2), exp); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL %s_hazard_after got %b exp 0", nm, hazard); end
  endtask

  task automatic test_loads();
    do_load(7, 0, 1'b1, 32'h80AA_BBCC, 32'hFFFF_FF80, "ld_byte_sext");
    do_load(7, 1, 1'b0, 32'h80AA_BBCC, 32'h0000_80AA, "ld_half_zext");
    do_load(8, 1, 1'b1, 32'h80AA_BBCC, 32'hFFFF_80AA, "ld_half_sext");
    do_load(9, 3, 1'b1, 32'h80AA_BBCC, 32'h80AA_BBCC, "ld_illegal_word");
  endtask

  task automatic test_stall();
    idle_inputs();
    ld_issue = 1'b1; ld_dest = 5'd4; ld_size = 2'd2;
    tick();
    ld_issue = 1'b0;
    dmem_valid = 1'b1; dmem_data = 32'hA5A5_0004;
    wr_en = 1'b1; wr_addr = 5'd3; result = 32'h3333_3333; rd_addr = {5'd0, 5'd3, 5'd4};
    settle();
    checks++; if (wr_stall !== 1'b1) begin errors++; $display("FAIL stall_asserted got %b exp 1", wr_stall); end
    checks++; if (port(1) !== 32'h0) begin errors++; $display("FAIL stall_no_alu_bypass got %h exp 0", port(1)); end
    tick();
    dmem_valid = 1'b0;
    settle();
    checks++; if (wr_stall !== 1'b0) begin errors++; $display("FAIL stall_released got %b exp 0", wr_stall); end
    checks++; if (port(0) !== 32'hA5A5_0004) begin errors++; $display("FAIL stall_load_written got %h exp a5a50004", port(0)); end
    tick();
    wr_en = 1'b0;
    settle();
    checks++; if (port(1) !== 32'h3333_3333) begin errors++; $display("FAIL stall_alu_written got %h exp 33333333", port(1)); end
  endtask

  task automatic test_reset_mid_load();
    int n;
    idle_inputs();
    wr_en = 1'b1; wr_addr = 5'd10; result = 32'h1111_2222;
    tick();
    wr_en = 1'b0; ld_issue = 1'b1; ld_dest = 5'd10; ld_size = 2'd2;
    tick();
    ld_issue = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dmem_valid = 1'b1; dmem_data = 32'hBAD0_BAD0; rd_addr = {5'd10, 5'd10, 5'd10};
    settle();
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL midload_sweep_hazard got %b exp 0", hazard); end
    wait_sweep(n);
    checks++; if (n != 32) begin errors++; $display("FAIL midload_sweep_length got %0d exp 32", n); end
    checks++; if (port(0) !== 32'h0) begin errors++; $display("FAIL midload_dest_cleared got %h exp 0", port(0)); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL midload_not_pending got %b exp 1", ld_ready); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL midload_hazard got %b exp 0", hazard); end
  endtask

  task automatic test_random();
    logic [31:0] m_regs [32];
    bit          m_pend;
    int          m_dest, m_size, wa, a, n;
    bit          m_sext, has_w, exp_stall, exp_haz, exp_ready;
    logic [31:0] wd, exp;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    wait_sweep(n);
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pend = 0; m_dest = 0; m_size = 0; m_sext = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      enable     = ($urandom_range(0, 3) != 0);
      wr_en      = $urandom_range(0, 1);
      wr_addr    = 5'($urandom_range(0, 31));
      wr_pc_sel  = ($urandom_range(0, 3) == 0);
      result     = $urandom;
      pc         = $urandom;
      ld_issue   = ($urandom_range(0, 2) == 0);
      ld_dest    = 5'($urandom_range(0, 31));
      ld_size    = 2'($urandom_range(0, 3));
      ld_sext    = $urandom_range(0, 1);
      dmem_valid = m_pend && ($urandom_range(0, 2) == 0);
      dmem_data  = $urandom;
      for (int p = 0; p < 3; p++) begin
        case ($urandom_range(0, 3))
          0:       rd_addr[p*5 +: 5] = wr_addr;
          1:       rd_addr[p*5 +: 5] = 5'(m_dest);
          default: rd_addr[p*5 +: 5] = 5'($urandom_range(0, 31));
        endcase
      end
      settle();
      exp_stall = wr_en && enable && dmem_valid && m_pend;
      has_w = 0; wa = 0; wd = '0;
      if (dmem_valid && m_pend) begin
        has_w = 1; wa = m_dest; wd = ld_model(dmem_data, m_size, m_sext);
      end else if (wr_en && enable) begin
        has_w = 1; wa = int'(wr_addr); wd = wr_pc_sel ? pc : result;
      end
      exp_haz = 0;
      for (int p = 0; p < 3; p++) begin
        a = int'(rd_addr[p*5 +: 5]);
        if (m_pend && !dmem_valid && m_dest != 0 && a == m_dest) exp_haz = 1;
        if (a == 0) exp = '0;
        else if (has_w && wa == a) exp = wd;
        else exp = m_regs[a];
        checks++;
        if (port(p) !== exp) begin
          errors++; $display("FAIL rand_read cyc %0d port %0d addr %0d got %h exp %h", cyc, p, a, port(p), exp);
        end
      end
      exp_ready = !m_pend || dmem_valid;
      checks++; if (wr_stall !== exp_stall) begin errors++; $display("FAIL rand_stall cyc %0d got %b exp %b", cyc, wr_stall, exp_stall); end
      checks++; if (hazard !== exp_haz) begin errors++; $display("FAIL rand_hazard cyc %0d got %b exp %b", cyc, hazard, exp_haz); end
      checks++; if (ld_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", cyc, ld_ready, exp_ready); end
      if (has_w && wa != 0) m_regs[wa] = wd;
      if (dmem_valid && m_pend) m_pend = 0;
      if (ld_issue && enable && exp_ready) begin
        m_pend = 1; m_dest = int'(ld_dest); m_size = int'(ld_size); m_sext = ld_sext;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_bypass();
    test_r0();
    test_loads();
    test_stall();
    test_reset_mid_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
